// File: rtl/audio_pkg.sv
// Shared types and constants for the audio voice scheduler and its per-voice contexts.
package audio_pkg;
  localparam int SAMPLE_W          = 16;
  localparam int DEFAULT_ADDR_W    = 20;
  localparam int DEFAULT_ADDR_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_SAT
  } state_e;
endpackage

// File: rtl/audio_voice_ctx.sv
// Per-voice playback context: pending start/stop requests, play flag, sample offset
// and the end-of-sample advance rule.
module audio_voice_ctx
  import audio_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int ADDR_STEP = DEFAULT_ADDR_STEP
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              apply,
  input  logic              start,
  input  logic              stop,
  input  logic              advance,
  input  logic [ADDR_W-1:0] len,
  input  logic              loop,
  output logic              active,
  output logic [ADDR_W-1:0] offset,
  output logic              done
);
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(ADDR_STEP);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              start_pend_q, start_pend_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   next_off;

  always_comb begin
    start_pend_d = start_pend_q | start;
    stop_pend_d  = stop_pend_q | stop;
    active_d     = active_q;
    offset_d     = offset_q;
    done_d       = 1'b0;
    next_off     = {1'b0, offset_q} + STEP;
    if (apply) begin
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      // Stop beats a simultaneous start; a zero-length start is meaningless.
      if (stop_pend_q | stop) begin
        active_d = 1'b0;
        offset_d = '0;
      end else if ((start_pend_q | start) && (len != '0)) begin
        active_d = 1'b1;
        offset_d = '0;
      end
    end else if (advance && active_q) begin
      if (next_off >= {1'b0, len}) begin
        offset_d = '0;
        if (!loop) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end else begin
        offset_d = next_off[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q     <= 1'b0;
      offset_q     <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      active_q     <= active_d;
      offset_q     <= offset_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      done_q       <= done_d;
    end
  end

  assign active = active_q;
  assign offset = offset_q;
  assign done   = done_q;
endmodule

// File: rtl/audio_voice_scheduler.sv
// Mixes one sample per codec request by walking all voices, fetching one RAM word
// per active voice, summing and saturating to 16 bits.
module audio_voice_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int ADDR_STEP  = DEFAULT_ADDR_STEP
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         sample_req,
  input  logic [NUM_VOICES-1:0]        voice_start,
  input  logic [NUM_VOICES-1:0]        voice_stop,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
  input  logic [NUM_VOICES-1:0]        voice_loop,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic                         ram_rd,
  input  logic signed [SAMPLE_W-1:0]   ram_data,
  output logic [SAMPLE_W-1:0]          LDATA,
  output logic [SAMPLE_W-1:0]          RDATA,
  output logic                         sample_valid,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_done,
  output logic                         overrun
);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_e                    state_q, state_d;
  logic [VW-1:0]             v_q, v_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [SAMPLE_W-1:0]       out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      req_q, req_d;
  logic                      req_prev_q, req_prev_d;
  logic [ADDR_W-1:0]         addr_hold_q, addr_hold_d;

  logic                      apply;
  logic                      req_edge;
  logic [NUM_VOICES-1:0]     advance_vec;
  logic [ADDR_W-1:0]         base_arr   [NUM_VOICES];
  logic [ADDR_W-1:0]         offset_arr [NUM_VOICES];
  logic [ADDR_W-1:0]         cur_addr;

  // Requests only take effect between frames, so a frame sees a stable voice set.
  assign apply    = (state_q == ST_IDLE);
  assign req_edge = req_q & ~req_prev_q;
  assign cur_addr = base_arr[v_q] + offset_arr[v_q];

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign base_arr[gi]    = voice_base[gi*ADDR_W +: ADDR_W];
    assign advance_vec[gi] = (state_q == ST_DATA) && (v_q == VW'(gi));

    audio_voice_ctx #(
      .ADDR_W   (ADDR_W),
      .ADDR_STEP(ADDR_STEP)
    ) u_ctx (
      .Clk    (Clk),
      .Reset  (Reset),
      .apply  (apply),
      .start  (voice_start[gi]),
      .stop   (voice_stop[gi]),
      .advance(advance_vec[gi]),
      .len    (voice_len[gi*ADDR_W +: ADDR_W]),
      .loop   (voice_loop[gi]),
      .active (voice_active[gi]),
      .offset (offset_arr[gi]),
      .done   (voice_done[gi])
    );
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    acc_d       = acc_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;
    addr_hold_d = addr_hold_q;
    req_d       = sample_req;
    req_prev_d  = req_q;
    ram_rd      = 1'b0;
    ram_addr    = addr_hold_q;
    if (req_edge && (state_q != ST_IDLE)) overrun_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          state_d = ST_ADDR;
          v_d     = '0;
          acc_d   = '0;
        end
      end
      ST_ADDR: begin
        if (voice_active[v_q]) begin
          ram_rd      = 1'b1;
          ram_addr    = cur_addr;
          addr_hold_d = cur_addr;
          state_d     = ST_DATA;
        end else if (v_q == LAST_V) begin
          state_d = ST_SAT;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      ST_DATA: begin
        acc_d = acc_q + ACC_W'(ram_data);
        if (v_q == LAST_V) begin
          state_d = ST_SAT;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_SAT: begin
        if (acc_q > SAT_MAX)      out_d = SAT_MAX[SAMPLE_W-1:0];
        else if (acc_q < SAT_MIN) out_d = SAT_MIN[SAMPLE_W-1:0];
        else                      out_d = acc_q[SAMPLE_W-1:0];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      v_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      req_q       <= 1'b0;
      req_prev_q  <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      req_q       <= req_d;
      req_prev_q  <= req_prev_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign LDATA        = out_q;
  assign RDATA        = out_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Self-checking bench: frame-level reference model predicting every output per cycle,
// plus directed frames with hand-computed results and randomized traffic.
module tb_audio_voice_scheduler;
  localparam int NV   = 4;
  localparam int AW   = 20;
  localparam int STEP = 4;
  localparam int RING = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   Reset;
  logic                   sample_req;
  logic [NV-1:0]          voice_start, voice_stop, voice_loop;
  logic [NV*AW-1:0]       voice_base, voice_len;
  logic [AW-1:0]          ram_addr;
  logic                   ram_rd;
  logic signed [15:0]     ram_data = '0;
  logic [15:0]            LDATA, RDATA;
  logic                   sample_valid;
  logic [NV-1:0]          voice_active, voice_done;
  logic                   overrun;

  audio_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .ADDR_STEP(STEP)) dut (
    .Clk(clk), .Reset(Reset), .sample_req(sample_req),
    .voice_start(voice_start), .voice_stop(voice_stop),
    .voice_base(voice_base), .voice_len(voice_len), .voice_loop(voice_loop),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .LDATA(LDATA), .RDATA(RDATA), .sample_valid(sample_valid),
    .voice_active(voice_active), .voice_done(voice_done), .overrun(overrun)
  );

  // Audio RAM: one-cycle read latency.
  logic signed [15:0] mem [0:4095];
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr[11:0]];

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          mc = 0;
  int          idle_from = 0;
  bit          req_cur, req_prev;
  bit [NV-1:0] m_active, pend_start, pend_stop, vis_active;
  int          m_off [NV];
  bit          e_rd    [RING];
  int          e_addr  [RING];
  bit          e_valid [RING];
  int          e_val   [RING];
  bit [NV-1:0] e_done  [RING];
  bit          exp_rd, exp_valid, exp_ov;
  int          exp_addr, exp_ldata;
  bit [NV-1:0] exp_active, exp_done;

  function automatic int clamp16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Lays out a whole frame starting after edge-detect cycle n.
  task automatic schedule_frame(input int n);
    int cur, sum, a, nxt, len, base;
    cur = n + 1;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_active[v]) begin
        base = int'(voice_base[v*AW +: AW]);
        len  = int'(voice_len[v*AW +: AW]);
        a    = (base + m_off[v]) & ((1 << AW) - 1);
        e_rd[cur % RING]   = 1'b1;
        e_addr[cur % RING] = a;
        sum += int'(mem[a & 4095]);
        nxt = m_off[v] + STEP;
        if (nxt >= len) begin
          m_off[v] = 0;
          if (!voice_loop[v]) begin
            m_active[v] = 1'b0;
            e_done[(cur + 2) % RING][v] = 1'b1;
          end
        end else begin
          m_off[v] = nxt;
        end
        cur += 2;
      end else begin
        cur += 1;
      end
    end
    e_valid[(cur + 1) % RING] = 1'b1;
    e_val[(cur + 1) % RING]   = clamp16(sum);
    idle_from = cur + 1;
  endtask

  always @(posedge clk) begin
    int  n, slot;
    bit  edge_now;
    n = mc;
    if (Reset) begin
      for (int i = 0; i < RING; i++) begin
        e_rd[i] = 0; e_addr[i] = 0; e_valid[i] = 0; e_val[i] = 0; e_done[i] = '0;
      end
      for (int v = 0; v < NV; v++) m_off[v] = 0;
      m_active = '0; pend_start = '0; pend_stop = '0; vis_active = '0;
      req_cur = 0; req_prev = 0; idle_from = n + 1;
      exp_rd = 0; exp_addr = 0; exp_valid = 0; exp_ldata = 0; exp_ov = 0;
      exp_active = '0; exp_done = '0;
    end else begin
      edge_now = req_cur && !req_prev;
      pend_start |= voice_start;
      pend_stop  |= voice_stop;
      if (edge_now && n < idle_from) exp_ov = 1'b1;
      if (n >= idle_from) begin
        for (int v = 0; v < NV; v++) begin
          if (pend_stop[v]) begin
            m_active[v] = 1'b0; m_off[v] = 0;
          end else if (pend_start[v] && voice_len[v*AW +: AW] != '0) begin
            m_active[v] = 1'b1; m_off[v] = 0;
          end
        end
        pend_start = '0;
        pend_stop  = '0;
        vis_active = m_active;
        if (edge_now) schedule_frame(n);
      end
      req_prev = req_cur;
      req_cur  = sample_req;
      slot = (n + 1) % RING;
      exp_rd = e_rd[slot];
      if (exp_rd) exp_addr = e_addr[slot];
      exp_valid = e_valid[slot];
      if (exp_valid) exp_ldata = e_val[slot];
      exp_done   = e_done[slot];
      vis_active = vis_active & ~e_done[slot];
      exp_active = vis_active;
      e_rd[slot] = 0; e_valid[slot] = 0; e_done[slot] = '0;
    end
    mc = n + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_rd", ram_rd, exp_rd);
      check("ram_addr", ram_addr, exp_addr);
      check("sample_valid", sample_valid, exp_valid);
      check("LDATA", $signed(LDATA), exp_ldata);
      check("RDATA", $signed(RDATA), exp_ldata);
      check("voice_active", voice_active, exp_active);
      check("voice_done", voice_done, exp_done);
      check("overrun", overrun, exp_ov);
    end
  end

  // ---------------- stimulus ----------------
  int          rd_log[$];
  bit [NV-1:0] done_seen;

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #2; end
  endtask

  task automatic pulse(input logic [NV-1:0] s, input logic [NV-1:0] p);
    voice_start = s; voice_stop = p;
    cyc(1);
    voice_start = '0; voice_stop = '0;
  endtask

  task automatic set_voice(input int v, input int base, input int len, input bit lp);
    voice_base[v*AW +: AW] = AW'(base);
    voice_len[v*AW +: AW]  = AW'(len);
    voice_loop[v]          = lp;
  endtask

  function automatic int rd_at(input int idx);
    return (rd_log.size() > idx) ? rd_log[idx] : -1;
  endfunction

  task automatic run_frame(input string name, input int exp_lat, input int exp_val);
    int got;
    got = -1;
    rd_log.delete();
    sample_req = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (ram_rd) rd_log.push_back(int'(ram_addr));
      done_seen |= voice_done;
      if (sample_valid) begin got = j - 1; break; end
    end
    check({name, " latency"}, got, exp_lat);
    check({name, " LDATA"}, $signed(LDATA), exp_val);
    $display("frame %s: latency %0d LDATA %0d reads %0d", name, got, $signed(LDATA), rd_log.size());
    @(posedge clk); #2;
    sample_req = 1'b0;
    cyc(1);
  endtask

  initial begin
    int lens[7] = '{0, 4, 6, 8, 12, 16, 20};
    int cnt;
    bit found;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    Reset = 1'b1; sample_req = 1'b0;
    voice_start = '0; voice_stop = '0; voice_loop = '0;
    voice_base = '0; voice_len = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(1);

    @(negedge clk);
    check("reset LDATA", LDATA, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset overrun", overrun, 0);
    @(posedge clk); #2;

    // No voices: bare FSM walk.
    run_frame("empty", 6, 0);
    check("empty reads", rd_log.size(), 0);

    // One-shot voice 0.
    mem[12'h100] = 16'sd1000; mem[12'h104] = 16'sd2000;
    set_voice(0, 'h100, 8, 1'b0);
    pulse(4'b0001, 4'b0000);
    done_seen = '0;
    run_frame("oneshot1", 7, 1000);
    check("oneshot1 addr", rd_at(0), 'h100);
    check("oneshot1 no done", done_seen[0], 0);
    run_frame("oneshot2", 7, 2000);
    check("oneshot2 addr", rd_at(0), 'h104);
    check("oneshot2 done", done_seen[0], 1);
    check("oneshot2 inactive", voice_active[0], 0);

    // Saturation with all voices active.
    for (int v = 0; v < NV; v++) begin
      set_voice(v, 'h200 + v * 'h100, 16, 1'b1);
      mem['h200 + v * 'h100]     = 16'sd20000;
      mem['h200 + v * 'h100 + 4] = -16'sd20000;
    end
    pulse(4'b1111, 4'b0000);
    run_frame("sat_pos", 10, 32767);
    check("sat_pos reads", rd_log.size(), 4);
    run_frame("sat_neg", 10, -32768);

    // Looping voice 1.
    pulse(4'b0000, 4'b1111);
    set_voice(1, 'h600, 8, 1'b1);
    mem[12'h600] = 16'sd111; mem[12'h604] = -16'sd222;
    pulse(4'b0010, 4'b0000);
    done_seen = '0;
    run_frame("loop1", 7, 111);
    check("loop1 addr", rd_at(0), 'h600);
    run_frame("loop2", 7, -222);
    check("loop2 addr", rd_at(0), 'h604);
    run_frame("loop3", 7, 111);
    check("loop3 addr", rd_at(0), 'h600);
    check("loop no done", done_seen, 0);

    // Simultaneous start+stop, then a second request edge mid-frame.
    set_voice(2, 'h700, 8, 1'b0);
    pulse(4'b0100, 4'b0100);
    cyc(1);
    check("start+stop voice2", voice_active, 4'b0010);
    sample_req = 1'b1; cyc(1);
    sample_req = 1'b0; cyc(1);
    sample_req = 1'b1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    check("overrun valid count", cnt, 1);
    check("overrun flag", overrun, 1);
    $display("frame overrun: valid pulses %0d overrun %0d", cnt, overrun);
    @(posedge clk); #2;
    sample_req = 1'b0;
    cyc(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int f = 0; f < 40; f++) begin
      int gap;
      bit dbl;
      gap = $urandom_range(1, 8);
      dbl = ($urandom_range(0, 4) == 0);
      for (int v = 0; v < NV; v++)
        set_voice(v, $urandom_range(0, 'hE00) & 'hFFC, lens[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
      for (int c = 0; c < gap + 24; c++) begin
        voice_start = ($urandom_range(0, 5) == 0) ? NV'($urandom) : '0;
        voice_stop  = ($urandom_range(0, 9) == 0) ? NV'($urandom) : '0;
        sample_req  = (c >= gap && c < gap + 2) || (dbl && c >= gap + 5 && c < gap + 7);
        cyc(1);
      end
      voice_start = '0; voice_stop = '0; sample_req = 1'b0;
      $display("random frame %0d: active %b LDATA %0d overrun %0d", f, voice_active, $signed(LDATA), overrun);
    end

    // Reset in the middle of a frame.
    pulse(4'b0000, 4'b1111);
    set_voice(0, 'h100, 8, 1'b1);
    pulse(4'b0001, 4'b0000);
    sample_req = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ram_rd) begin found = 1'b1; break; end
    end
    check("reset frame reached read", found, 1);
    @(posedge clk); #2;
    Reset = 1'b1; sample_req = 1'b0;
    cyc(1);
    Reset = 1'b0;
    @(negedge clk);
    check("midreset sample_valid", sample_valid, 0);
    check("midreset ram_rd", ram_rd, 0);
    check("midreset ram_addr", ram_addr, 0);
    check("midreset LDATA", LDATA, 0);
    check("midreset voice_active", voice_active, 0);
    check("midreset overrun", overrun, 0);
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    check("midreset no valid", cnt, 0);
    $display("frame reset: valid pulses after reset %0d", cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/audio_voice_scheduler.md
AUDIO_VOICE_SCHEDULER -- requirements
Module: audio_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of sample voices sharing the audio RAM.
REQ-002 SHALL have parameter ADDR_W, default 20, audio RAM address width.
REQ-003 SHALL have parameter ADDR_STEP, default 4, address increment per fetched sample.
REQ-004 SHALL have port Clk  input  1  sole clock, all logic on posedge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_req  input  1  codec sample strobe (level, data_over), rising edge starts one mix frame.
REQ-007 SHALL have port voice_start  input  NUM_VOICES  one-cycle start pulse per voice.
REQ-008 SHALL have port voice_stop  input  NUM_VOICES  one-cycle stop pulse per voice.
REQ-009 SHALL have port voice_base  input  NUM_VOICES*ADDR_W  start address per voice, voice v at bits [v*ADDR_W +: ADDR_W].
REQ-010 SHALL have port voice_len  input  NUM_VOICES*ADDR_W  length in address units per voice.
REQ-011 SHALL have port voice_loop  input  NUM_VOICES  1 = wrap to base at end, 0 = one-shot.
REQ-012 SHALL have port ram_addr  output  ADDR_W  audio RAM read address.
REQ-013 SHALL have port ram_rd  output  1  high in cycles that issue a read.
REQ-014 SHALL have port ram_data  input  16  signed sample, valid exactly 1 cycle after ram_addr.
REQ-015 SHALL have port LDATA / RDATA  output  16 each  mixed sample, identical on both channels.
REQ-016 SHALL have port sample_valid  output  1  one-cycle pulse when LDATA/RDATA update.
REQ-017 SHALL have port voice_active  output  NUM_VOICES  per-voice playing flag.
REQ-018 SHALL have port voice_done  output  NUM_VOICES  one-cycle pulse when a one-shot voice ends.
REQ-019 SHALL have port overrun  output  1  sticky, set when a sample_req edge arrives while not IDLE.

Function
REQ-020 SHALL register sample_req once and detect a rise as current=1, previous=0.
REQ-021 SHALL implement FSM IDLE -> ADDR -> (DATA) -> ... -> SAT -> IDLE, with voice index v from 0 to NUM_VOICES-1.
REQ-022 IDLE SHALL go to ADDR with v=0 and accumulator=0 on a detected edge; otherwise it SHALL stay in IDLE.
REQ-023 In ADDR with voice v inactive: 1 cycle, ram_rd=0, then v+1 (ADDR) or SAT after the last voice.
REQ-024 In ADDR with voice v active: ram_addr=base_v+offset_v, ram_rd=1, then DATA.
REQ-025 DATA SHALL sign-extend ram_data and add it to an accumulator of 16+clog2(NUM_VOICES) bits, advance the voice, then go to v+1 (ADDR) or SAT.
REQ-026 Advance: if offset+ADDR_STEP >= len, then loop=1 sets offset=0, and loop=0 clears active and pulses voice_done[v] for 1 cycle; otherwise offset += ADDR_STEP.
REQ-027 SAT SHALL clamp the accumulator to [-32768, 32767], write it to LDATA and RDATA, and pulse sample_valid on the following cycle; the next state SHALL be IDLE.
REQ-028 Latency: sample_valid SHALL be high exactly NUM_VOICES+A+2 cycles after the edge-detect cycle, where A is the number of voices active at frame start.
REQ-029 start/stop pulses SHALL be latched into per-voice pending bits and applied only in IDLE, so a frame never sees a voice change mid-frame.
REQ-030 Applying a start SHALL set active=1 and offset=0, and SHALL restart a voice that is already active.
REQ-031 A start with len=0 SHALL be ignored.
REQ-032 If start and stop are pending together, stop SHALL win.
REQ-033 A pending request SHALL be applied in the IDLE cycle where the edge is detected, before the frame reads that voice.
REQ-034 An edge seen outside IDLE SHALL be dropped and SHALL set overrun; only Reset clears overrun.
REQ-035 ram_rd SHALL be 0 in IDLE, SAT and DATA.
REQ-036 ram_addr SHALL hold its last value when ram_rd=0.

Reset
REQ-037 Reset SHALL force: state IDLE; all active, offset and pending bits 0; LDATA=RDATA=0; sample_valid=0; voice_done=0; ram_rd=0; ram_addr=0; overrun=0; edge register=0.
REQ-038 Reset mid-frame SHALL abandon the frame with no sample_valid; Reset SHALL take priority over every other input.

Structure
REQ-039 A shared package audio_pkg SHALL hold the FSM state enum, sample width (16) and default ADDR_W/ADDR_STEP constants.
REQ-040 One sub-module, audio_voice_ctx, SHALL hold per-voice active/offset/pending registers and the advance logic, instantiated NUM_VOICES times.

Verification
REQ-041 Bench: no voices active, raise sample_req -> sample_valid 6 cycles after edge detect, LDATA=RDATA=0, ram_rd never high.
REQ-042 Bench: voice0 base=0x100, len=8, loop=0; RAM holds 1000, 2000 -> frames output 1000 then 2000 at addrs 0x100 and 0x104; voice_done[0] pulses in the second frame; voice_active[0]=0 after it.
REQ-043 Bench: all 4 voices active reading 20000 each -> LDATA=32767; all reading -20000 -> LDATA=-32768; latency 10 cycles.
REQ-044 Bench: voice1 loop=1, len=8, 3 frames -> addrs base, base+4, base, with no voice_done.
REQ-045 Bench: second sample_req rise during ADDR -> overrun=1, exactly one sample_valid; start+stop pulsed together on voice2 -> voice2 stays inactive.
REQ-046 Bench: Reset asserted in DATA -> next cycle state IDLE, all outputs at reset values, no sample_valid.
